tlu_aligned_combiner: RTL and testbench
=======================================

Name: tlu_aligned_combiner

Overview:
- Parametrised successor to the trade logic unit; sits after the strategy modules (SMA, mean-reversion, Z-score and any later additions).
- Accepts NUM_STRAT strategy buy/sell flags, each with its own valid and arbitrary relative latency, and re-aligns them in per-channel skew FIFOs.
- Forms runtime-weighted buy/sell scores and applies runtime thresholds.
- A cooldown state machine suppresses back-to-back trade signals.

Parameters:
- NUM_STRAT, 3, number of strategy channels (1..8).
- WEIGHT_W, 3, width of each per-channel weight.
- SKEW_DEPTH, 4, entries per channel alignment FIFO (power of 2, ≥2).
- COOLDOWN, 4, number of aligned decisions suppressed after a trade signal (0 disables).
- SCORE_W (derived), WEIGHT_W+$clog2(NUM_STRAT+1), score and threshold width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, incoming strat_valid is ignored; stored entries still drain.
- flush  in  1  synchronous clear of FIFOs, pipeline and FSM; config is untouched.
- strat_valid  in  NUM_STRAT  per-channel sample-valid strobe.
- strat_buy  in  NUM_STRAT  per-channel buy flag, qualified by strat_valid.
- strat_sell  in  NUM_STRAT  per-channel sell flag, qualified by strat_valid.
- buy_weight  in  NUM_STRAT*WEIGHT_W  packed buy weights, channel 0 in the LSBs.
- sell_weight  in  NUM_STRAT*WEIGHT_W  packed sell weights.
- buy_threshold  in  SCORE_W  buy fires when buy score ≥ this; 0 disables buy.
- sell_threshold  in  SCORE_W  sell fires when sell score ≥ this; 0 disables sell.
- buy_signal  out  1  one-cycle buy pulse.
- sell_signal  out  1  one-cycle sell pulse.
- data_valid_end  out  1  one-cycle pulse per aligned decision, including suppressed and no-trade decisions.
- buy_score  out  SCORE_W  registered buy score of the current decision.
- sell_score  out  SCORE_W  registered sell score of the current decision.
- overflow  out  1  sticky: a channel wrote while its FIFO was full.

Behaviour:
- Reset (asynchronous, rst high): all outputs 0, FIFOs empty, FSM in READY, cooldown counter 0. The flush input produces the same state synchronously.
- Stage 1, capture: on each edge where enable=1 and strat_valid[i]=1, push {buy,sell}[i] into FIFO i.
  - If FIFO i is full, the sample is dropped and overflow is set. Overflow clears only on rst or flush.
  - The other channels are unaffected.
- Stage 2, align and score: when every FIFO is non-empty, pop one entry from each on the same edge.
  - buy_score = sum of buy_weight[i] over popped entries with buy=1. sell_score is formed the same way.
  - Arithmetic is unsigned and full width, so it never overflows.
  - A push and a pop on the same FIFO in the same cycle are both honoured, and occupancy is unchanged.
  - An entry pushed on edge E is poppable at edge E+1 at the earliest.
- Stage 3, decide (registered):
  - buy_hit = buy_threshold≠0 and buy_score≥buy_threshold. sell_hit is formed the same way.
  - If both hit, the strictly larger score wins. If the scores are equal, neither fires.
- FSM:
  - READY: on a decision with a winning side, pulse that signal. If COOLDOWN>0, load the counter with COOLDOWN and go to COOL.
  - COOL: on each decision, buy_signal and sell_signal are forced 0 and the counter decrements. At 0, return to READY.
  - Only decisions decrement the counter; idle clocks do not.
- Latency: if the last-arriving channel's valid is sampled at edge E0, then data_valid_end, buy_score, sell_score and buy/sell_signal are high for the single cycle after edge E0+2.
- Throughput: one decision per clock once all channels are streaming.
- Config ports are sampled at stage 2 (weights) and stage 3 (thresholds). Changes take effect on the next decision; no shadowing.
- flush or rst mid-operation: in-flight entries are discarded and no pulse is emitted for them. A flush in the same cycle as strat_valid discards that sample too.
- buy_signal and sell_signal are never high in the same cycle.

Test Plan:
- Skew alignment: COOLDOWN=0, weights {4,1,2}, buy_threshold=2. Channels 0 and 1 assert valid with buy=1 at E0; channel 2 asserts buy=1 at E0+2 -> a single data_valid_end after E0+4, buy_score=7, buy_signal=1.
- Tie: buy and sell weights all 1, thresholds 1. Channel 0 buy=1, channel 1 sell=1, channel 2 neither -> both scores 1, data_valid_end=1, buy_signal=sell_signal=0.
- Cooldown: COOLDOWN=4, six consecutive decisions with buy_score 3 and threshold 2 -> buy_signal on decision 1 only. Decisions 2–5 are suppressed, buy_signal fires again on decision 6, and data_valid_end fires on all six.
- Overflow: SKEW_DEPTH=4. Channel 0 sends 5 valids while channel 1 is silent -> overflow=1 after the 5th. Channel 1 then sends 4 valids -> exactly 4 decisions, pairing channel-0 samples 1–4.
- Threshold-0 disable: sell_threshold=0 with all sells asserted -> sell_signal stays 0 while sell_score reports the full weighted sum.
- Reset/flush mid-flight: assert rst asynchronously between clock edges with 2 entries queued -> all outputs drop immediately, and no decision appears after release. Repeat with flush and check the same result at the next edge.

Source files
------------

// File: rtl/tlu_aligned_combiner.sv
// Trade logic combiner: re-aligns skewed strategy flags, scores them with
// runtime weights, thresholds the scores and rate-limits trades via cooldown.
module tlu_aligned_combiner #(
   parameter int NUM_STRAT  = 3,
   parameter int WEIGHT_W   = 3,
   parameter int SKEW_DEPTH = 4,
   parameter int COOLDOWN   = 4,
   parameter int SCORE_W    = WEIGHT_W + $clog2(NUM_STRAT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          flush,
   input  logic [NUM_STRAT-1:0]          strat_valid,
   input  logic [NUM_STRAT-1:0]          strat_buy,
   input  logic [NUM_STRAT-1:0]          strat_sell,
   input  logic [NUM_STRAT*WEIGHT_W-1:0] buy_weight,
   input  logic [NUM_STRAT*WEIGHT_W-1:0] sell_weight,
   input  logic [SCORE_W-1:0]            buy_threshold,
   input  logic [SCORE_W-1:0]            sell_threshold,
   output logic                          buy_signal,
   output logic                          sell_signal,
   output logic                          data_valid_end,
   output logic [SCORE_W-1:0]            buy_score,
   output logic [SCORE_W-1:0]            sell_score,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(SKEW_DEPTH);
   localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   typedef enum logic {
      READY,
      COOL
   } state_t;

   logic [NUM_STRAT-1:0] head_buy;
   logic [NUM_STRAT-1:0] head_sell;
   logic [NUM_STRAT-1:0] not_empty;
   logic [NUM_STRAT-1:0] is_full;
   logic [NUM_STRAT-1:0] push_req;
   logic [NUM_STRAT-1:0] drop;
   logic                 pop;

   assign push_req = enable ? strat_valid : '0;
   assign drop     = push_req & is_full;
   assign pop      = &not_empty;

   // Per-channel skew FIFO; pointers carry an extra wrap bit for full/empty.
   genvar g;
   generate
      for (g = 0; g < NUM_STRAT; g++) begin : g_fifo
         logic [1:0]     mem [SKEW_DEPTH];
         logic [PTR_W:0] wr_ptr;
         logic [PTR_W:0] rd_ptr;
         logic           wr_en;

         assign wr_en        = push_req[g] && !is_full[g] && !flush;
         assign not_empty[g] = (wr_ptr != rd_ptr);
         assign is_full[g]   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                               (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
         assign head_buy[g]  = mem[rd_ptr[PTR_W-1:0]][1];
         assign head_sell[g] = mem[rd_ptr[PTR_W-1:0]][0];

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_ptr[PTR_W-1:0]] <= {strat_buy[g], strat_sell[g]};
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end else if (flush) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end else begin
               if (wr_en) begin
                  wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (flush) begin
         overflow <= 1'b0;
      end else if (|drop) begin
         overflow <= 1'b1;
      end
   end

   // Stage 2: weighted scores of the aligned heads
   logic [SCORE_W-1:0] sum_buy;
   logic [SCORE_W-1:0] sum_sell;

   always_comb begin
      sum_buy  = '0;
      sum_sell = '0;
      for (int i = 0; i < NUM_STRAT; i++) begin
         if (head_buy[i]) begin
            sum_buy = sum_buy + SCORE_W'(buy_weight[i*WEIGHT_W +: WEIGHT_W]);
         end
         if (head_sell[i]) begin
            sum_sell = sum_sell + SCORE_W'(sell_weight[i*WEIGHT_W +: WEIGHT_W]);
         end
      end
   end

   logic               s2_valid;
   logic [SCORE_W-1:0] s2_buy;
   logic [SCORE_W-1:0] s2_sell;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_buy   <= '0;
         s2_sell  <= '0;
      end else if (flush) begin
         s2_valid <= 1'b0;
         s2_buy   <= '0;
         s2_sell  <= '0;
      end else begin
         s2_valid <= pop;
         if (pop) begin
            s2_buy  <= sum_buy;
            s2_sell <= sum_sell;
         end
      end
   end

   // Stage 3: thresholds, tie-break and cooldown
   logic buy_hit;
   logic sell_hit;
   logic win_buy;
   logic win_sell;

   assign buy_hit  = (buy_threshold != '0) && (s2_buy >= buy_threshold);
   assign sell_hit = (sell_threshold != '0) && (s2_sell >= sell_threshold);
   assign win_buy  = buy_hit && (!sell_hit || (s2_buy > s2_sell));
   assign win_sell = sell_hit && (!buy_hit || (s2_sell > s2_buy));

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic             next_buy;
   logic             next_sell;

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_buy   = 1'b0;
      next_sell  = 1'b0;
      if (s2_valid) begin
         unique case (state)
            READY: begin
               next_buy  = win_buy;
               next_sell = win_sell;
               if ((win_buy || win_sell) && (COOLDOWN > 0)) begin
                  next_state = COOL;
                  next_cnt   = CNT_W'(COOLDOWN);
               end
            end
            COOL: begin
               next_cnt = cnt - CNT_W'(1);
               if (cnt <= CNT_W'(1)) begin
                  next_state = READY;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= READY;
         cnt            <= '0;
         buy_signal     <= 1'b0;
         sell_signal    <= 1'b0;
         data_valid_end <= 1'b0;
         buy_score      <= '0;
         sell_score     <= '0;
      end else if (flush) begin
         state          <= READY;
         cnt            <= '0;
         buy_signal     <= 1'b0;
         sell_signal    <= 1'b0;
         data_valid_end <= 1'b0;
         buy_score      <= '0;
         sell_score     <= '0;
      end else begin
         state          <= next_state;
         cnt            <= next_cnt;
         buy_signal     <= next_buy;
         sell_signal    <= next_sell;
         data_valid_end <= s2_valid;
         if (s2_valid) begin
            buy_score  <= s2_buy;
            sell_score <= s2_sell;
         end
      end
   end

endmodule

// File: tb/tb_tlu_aligned_combiner.sv
// Bench for tlu_aligned_combiner: queue-based reference model under random
// stimulus plus directed skew, tie, cooldown, overflow and reset/flush cases.
module tb_tlu_aligned_combiner;

   localparam int N  = 3;
   localparam int WW = 3;
   localparam int SD = 4;
   localparam int CD = 4;
   localparam int SW = WW + $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          flush;
   logic [N-1:0]  strat_valid;
   logic [N-1:0]  strat_buy;
   logic [N-1:0]  strat_sell;
   logic [N*WW-1:0] buy_weight;
   logic [N*WW-1:0] sell_weight;
   logic [SW-1:0] buy_threshold;
   logic [SW-1:0] sell_threshold;
   logic          buy_signal;
   logic          sell_signal;
   logic          data_valid_end;
   logic [SW-1:0] buy_score;
   logic [SW-1:0] sell_score;
   logic          overflow;

   tlu_aligned_combiner #(
      .NUM_STRAT(N), .WEIGHT_W(WW), .SKEW_DEPTH(SD), .COOLDOWN(CD)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .strat_valid(strat_valid), .strat_buy(strat_buy),
      .strat_sell(strat_sell), .buy_weight(buy_weight),
      .sell_weight(sell_weight), .buy_threshold(buy_threshold),
      .sell_threshold(sell_threshold), .buy_signal(buy_signal),
      .sell_signal(sell_signal), .data_valid_end(data_valid_end),
      .buy_score(buy_score), .sell_score(sell_score),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   // Reference model: queues of {buy,sell} per channel, a pending decision
   // from the last pop, and a count of decisions still to suppress.
   logic [1:0] mq [N][$];
   bit m_ovf;
   bit pend;
   int pend_b, pend_s;
   int cool;
   bit e_dve, e_buy, e_sell;
   int e_bs, e_ss;

   function automatic int wsel(input logic [N*WW-1:0] w, input int i);
      return int'(w[i*WW +: WW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ovf = 0; pend = 0; cool = 0;
      e_dve = 0; e_buy = 0; e_sell = 0; e_bs = 0; e_ss = 0;
   endtask

   task automatic model_edge();
      bit all_ne, bh, sh, wb, ws;
      bit push_ok [N];
      int bs, ss;
      e_dve = 0; e_buy = 0; e_sell = 0;
      if (pend) begin
         e_dve = 1; e_bs = pend_b; e_ss = pend_s;
         bh = (buy_threshold != 0) && (pend_b >= int'(buy_threshold));
         sh = (sell_threshold != 0) && (pend_s >= int'(sell_threshold));
         wb = bh && (!sh || pend_b > pend_s);
         ws = sh && (!bh || pend_s > pend_b);
         if (cool > 0) cool--;
         else if (wb || ws) begin
            e_buy = wb; e_sell = ws; cool = CD;
         end
      end
      all_ne = 1;
      for (int i = 0; i < N; i++) begin
         if (mq[i].size() == 0) all_ne = 0;
         push_ok[i] = 0;
         if (enable && strat_valid[i]) begin
            if (mq[i].size() < SD) push_ok[i] = 1;
            else m_ovf = 1;
         end
      end
      pend = all_ne;
      if (all_ne) begin
         bs = 0; ss = 0;
         for (int i = 0; i < N; i++) begin
            logic [1:0] e;
            e = mq[i].pop_front();
            if (e[1]) bs += wsel(buy_weight, i);
            if (e[0]) ss += wsel(sell_weight, i);
         end
         pend_b = bs; pend_s = ss;
      end
      for (int i = 0; i < N; i++)
         if (push_ok[i]) mq[i].push_back({strat_buy[i], strat_sell[i]});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst || flush) model_reset();
      else model_edge();
      #1;
      check("dve", data_valid_end, e_dve);
      check("buy_sig", buy_signal, e_buy);
      check("sell_sig", sell_signal, e_sell);
      check("buy_score", buy_score, e_bs);
      check("sell_score", sell_score, e_ss);
      check("overflow", overflow, m_ovf);
   endtask

   task automatic idle();
      strat_valid = '0; strat_buy = '0; strat_sell = '0;
      flush = 0; enable = 1;
   endtask

   task automatic do_flush();
      idle(); flush = 1; tick(); flush = 0;
   endtask

   task automatic send(input logic [N-1:0] v, input logic [N-1:0] b,
                       input logic [N-1:0] s);
      strat_valid = v; strat_buy = b; strat_sell = s; tick();
   endtask

   int k, ndec;

   initial begin
      rst = 1; idle();
      buy_weight = '0; sell_weight = '0;
      buy_threshold = '0; sell_threshold = '0;
      model_reset();
      #1;
      check("rst_dve", data_valid_end, 0);
      check("rst_buy", buy_signal, 0);
      check("rst_ovf", overflow, 0);
      tick(); tick();
      rst = 0;
      tick();

      // Skew alignment
      buy_weight = {3'd2, 3'd1, 3'd4}; buy_threshold = 2; sell_threshold = 0;
      send(3'b011, 3'b011, 3'b000);
      send(3'b000, 3'b000, 3'b000);
      send(3'b100, 3'b100, 3'b000);
      idle(); tick();
      check("skew_early", data_valid_end, 0);
      tick();
      check("skew_dve", data_valid_end, 1);
      check("skew_score", buy_score, 7);
      check("skew_buy", buy_signal, 1);
      tick();
      check("skew_single", data_valid_end, 0);
      do_flush();

      // Tie between equal scores
      buy_weight = {3'd1, 3'd1, 3'd1}; sell_weight = {3'd1, 3'd1, 3'd1};
      buy_threshold = 1; sell_threshold = 1;
      send(3'b111, 3'b001, 3'b010);
      idle(); tick(); tick();
      check("tie_dve", data_valid_end, 1);
      check("tie_buy", buy_signal, 0);
      check("tie_sell", sell_signal, 0);
      check("tie_bs", buy_score, 1);
      check("tie_ss", sell_score, 1);
      do_flush();

      // Cooldown over six back-to-back decisions
      buy_threshold = 2; sell_threshold = 0;
      k = 0;
      for (int j = 0; j < 10; j++) begin
         if (j < 6) send(3'b111, 3'b111, 3'b000);
         else begin idle(); tick(); end
         if (data_valid_end) begin
            k++;
            check("cd_pulse", buy_signal, (k == 1 || k == 6) ? 1 : 0);
         end
      end
      check("cd_count", k, 6);
      do_flush();

      // Overflow: channel 0 over-fills while channel 1 is silent
      buy_weight = {3'd1, 3'd2, 3'd4}; buy_threshold = 0;
      send(3'b101, 3'b101, 3'b000);
      send(3'b101, 3'b100, 3'b000);
      send(3'b101, 3'b101, 3'b000);
      send(3'b101, 3'b001, 3'b000);
      check("ovf_before", overflow, 0);
      send(3'b101, 3'b000, 3'b000);
      check("ovf_set", overflow, 1);
      k = 0;
      for (int j = 0; j < 10; j++) begin
         if (j < 4) send(3'b010, 3'b010, 3'b000);
         else begin idle(); tick(); end
         if (data_valid_end) k++;
      end
      check("ovf_decisions", k, 4);
      check("ovf_sticky", overflow, 1);
      do_flush();
      check("ovf_flushed", overflow, 0);

      // Threshold 0 disables sell while score still reports
      sell_weight = {3'd7, 3'd5, 3'd3}; sell_threshold = 0; buy_threshold = 0;
      send(3'b111, 3'b000, 3'b111);
      idle(); tick(); tick();
      check("thr0_sig", sell_signal, 0);
      check("thr0_score", sell_score, 15);
      do_flush();

      // Asynchronous reset and flush with entries in flight
      for (int r = 0; r < 2; r++) begin
         buy_threshold = 2;
         send(3'b111, 3'b111, 3'b000);
         send(3'b111, 3'b111, 3'b000);
         send(3'b001, 3'b001, 3'b000);
         send(3'b001, 3'b001, 3'b000);
         if (r == 0) begin
            #2 rst = 1;
            #1;
            model_reset();
            check("arst_dve", data_valid_end, 0);
            check("arst_score", buy_score, 0);
            tick();
            rst = 0;
         end else begin
            idle(); flush = 1; tick(); flush = 0;
            check("flush_dve", data_valid_end, 0);
            check("flush_score", buy_score, 0);
         end
         idle();
         ndec = 0;
         for (int j = 0; j < 5; j++) begin
            tick();
            if (data_valid_end) ndec++;
         end
         check("post_clear_dec", ndec, 0);
      end

      // Randomised streaming against the model
      for (int j = 0; j < 600; j++) begin
         if (j % 40 == 0) begin
            buy_weight = N*WW'($urandom);
            sell_weight = N*WW'($urandom);
            buy_threshold = SW'($urandom_range(0, 16));
            sell_threshold = SW'($urandom_range(0, 16));
         end
         enable = ($urandom_range(0, 15) != 0);
         flush = ($urandom_range(0, 79) == 0);
         for (int i = 0; i < N; i++)
            strat_valid[i] = ($urandom_range(0, 3) != 0);
         strat_buy = N'($urandom);
         strat_sell = N'($urandom);
         tick();
         check("excl", buy_signal & sell_signal, 0);
      end
      idle();
      for (int j = 0; j < 8; j++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
